keypad_time_entry_ctrl: RTL and testbench
=========================================

// Module: keypad_time_entry_ctrl
// PURPOSE
//  Sequences the 10-key keypad encoder for microwave cook-time entry. It debounces
//  the encoder's digit code and all_off flag, accepts one digit per press/release
//  cycle and shifts it into a 4-digit BCD MM:SS buffer. On start it commits a
//  cook time to the timer block. Sits between the keypad encoder and the cook timer/FSM.
// PARAMETERS
//  STABLE_CYCLES   4  consecutive cycles a valid code (0-9) must hold before acceptance
//  RELEASE_CYCLES  4  consecutive cycles all_off must hold before the next press is armed
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   entry allowed; low = FSM to IDLE, counters cleared, buffer kept
//  digit        in   4   encoder code: 0-9 = key, 4'hF = none/multiple keys
//  all_off      in   1   encoder flag: no key pressed
//  lock         in   1   cooking in progress; digits and start are ignored
//  clear        in   1   one-cycle pulse: empty the entry buffer
//  start        in   1   one-cycle pulse: commit the entered time
//  bcd_time     out  16  live buffer {M10,M1,S10,S1}, 4 bits each
//  digit_count  out  3   digits entered, 0..4
//  key_strobe   out  1   1-cycle pulse: digit accepted into the buffer
//  key_reject   out  1   1-cycle pulse: digit debounced but dropped (buffer full or lock)
//  commit       out  1   1-cycle pulse: commit_time is valid
//  commit_time  out  16  committed BCD time, held until the next commit
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, debounce counter 0, buffer 0.
//  FSM, evaluated when enable=1:
//   IDLE:     digit<=9 & !all_off -> DEBOUNCE; latch code; cnt=1.
//   DEBOUNCE: same code -> cnt++. Code change -> relatch code, cnt=1.
//             Code 4'hF or all_off -> IDLE.
//             cnt reaches STABLE_CYCLES -> accept or reject, go to HELD.
//   HELD:     all_off -> RELEASE with cnt=1. Otherwise stay; code changes are ignored.
//   RELEASE:  all_off -> cnt++; cnt reaches RELEASE_CYCLES -> IDLE.
//             !all_off -> back to HELD (bounce on release).
//  Accept or reject, in the same cycle as leaving DEBOUNCE:
//   lock=1 or digit_count=4 -> key_reject pulse, buffer unchanged.
//   Otherwise buffer <= {buffer[11:0], code}, digit_count++, key_strobe pulse.
//  Latency: key_strobe fires STABLE_CYCLES cycles after the first valid sample.
//   bcd_time and digit_count update in that same cycle.
//  Commit: start=1 & !lock & bcd_time!=0 -> commit pulse next cycle.
//   commit_time <= (normalised) buffer; buffer and digit_count cleared.
//   start with a zero buffer or with lock=1 -> no commit, no state change.
//  Priority when events coincide: reset > clear > start > digit accept.
//   clear drops any same-cycle start or digit (no strobe or reject pulses).
//   start drops a same-cycle accepted digit (key_reject pulses).
//  clear acts regardless of lock or enable. clear and start do not disturb the FSM.
//  enable falling mid-debounce: press discarded, FSM to IDLE, no pulses.
//  Pulses are single-cycle; a held key never re-triggers before the release window completes.
// CONFIGURATION
//  TIME_NORMALIZE_EN defined: on commit, if seconds field S10S1 > 59, the time is normalised.
//   Seconds -= 60 and minutes += 1 (e.g. 00:90 -> 01:30).
//   If minutes would exceed 99, the result is clamped to 99:59.
//   Normalisation is applied in the commit cycle; latency is unchanged.
//  Undefined: commit_time = raw buffer (00:90 stays 16'h0090). The buffer is never normalised.
// TESTING
//  Press 5 for 6 cycles, release 6 -> key_strobe once at cycle 4; bcd_time=16'h0005, count=1.
//  Bouncy press 5,F,5,5,5,5 -> one strobe only, 4 cycles after the last restart.
//  Keys 1,2,3,0,7 -> bcd_time=16'h1230 after 4 digits; 5th digit gives key_reject, count=4.
//  Buffer 16'h0130, start -> commit=1 next cycle; commit_time=16'h0130; bcd_time=0, count=0.
//  Buffer 16'h0090, start -> commit_time 16'h0130 with TIME_NORMALIZE_EN, else 16'h0090.
//   Buffer 16'h9975 -> 16'h9959 with TIME_NORMALIZE_EN.
//  Same-cycle events: clear+start -> no commit, buffer 0. lock=1 + start -> no commit.
//   lock=1 + key press -> key_reject.
//   Reset asserted in DEBOUNCE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/keypad_time_entry_if.sv
// Keypad time-entry bus: control inputs from the keypad encoder / cook FSM
// and the entry buffer, pulses and committed time returned to them.
interface keypad_time_entry_if;
  logic        enable;
  logic [3:0]  digit;
  logic        all_off;
  logic        lock;
  logic        clear;
  logic        start;
  logic [15:0] bcd_time;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        key_reject;
  logic        commit;
  logic [15:0] commit_time;

  modport master (
    output enable, digit, all_off, lock, clear, start,
    input  bcd_time, digit_count, key_strobe, key_reject, commit, commit_time
  );

  modport slave (
    input  enable, digit, all_off, lock, clear, start,
    output bcd_time, digit_count, key_strobe, key_reject, commit, commit_time
  );
endinterface

// File: rtl/keypad_time_entry_ctrl.sv
// Keypad cook-time entry controller.
// Debounces the keypad encoder, shifts one BCD digit per press/release cycle
// into a 4-digit MM:SS buffer and commits it to the cook timer on start.
// Optional feature macro: TIME_NORMALIZE_EN (seconds > 59 carried into minutes
// on commit, clamped to 99:59).
module keypad_time_entry_ctrl #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_time_entry_if.slave    bus
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         code_q, code_d;
  logic [15:0]        buf_q, buf_d;
  logic [2:0]         count_q, count_d;
  logic               strobe_q, strobe_d;
  logic               reject_q, reject_d;
  logic               commit_q, commit_d;
  logic [15:0]        ctime_q, ctime_d;

  logic               valid_s;
  logic               press_done_s;
  logic               commit_go_s;
  logic [15:0]        commit_val_s;

`ifdef TIME_NORMALIZE_EN
  // Carry seconds 60..99 into minutes; the seconds units digit is unaffected
  // because subtracting 60 only touches the tens digit.
  function automatic logic [15:0] normalize_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:4] >= 4'd6) begin
      if (t[15:8] == 8'h99) begin
        r = 16'h9959;
      end else begin
        r[7:4] = t[7:4] - 4'd6;
        if (t[11:8] == 4'd9) begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end else begin
          r[11:8]  = t[11:8] + 4'd1;
        end
      end
    end else begin
      r = t;
    end
    return r;
  endfunction

  assign commit_val_s = normalize_time(buf_q);
`else
  assign commit_val_s = buf_q;
`endif

  assign valid_s = (bus.digit <= 4'd9) && !bus.all_off;

  // Press/release sequencing: debounce a press, then wait out a quiet release window.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    press_done_s = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_s) begin
            state_d = S_DEBOUNCE;
            code_d  = bus.digit;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (!valid_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (bus.digit != code_q) begin
            code_d  = bus.digit;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            press_done_s = 1'b1;
            state_d      = S_HELD;
            cnt_d        = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (bus.all_off) begin
            state_d = S_RELEASE;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        S_RELEASE: begin
          if (!bus.all_off) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A zero buffer or a locked oven makes start a no-op, so a same-cycle digit still lands.
  assign commit_go_s = bus.start && !bus.lock && (buf_q != 16'h0000) && !bus.clear;

  // Buffer, commit and pulse updates; clear beats start beats a digit accept.
  always_comb begin
    buf_d    = buf_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    reject_d = 1'b0;
    commit_d = 1'b0;
    ctime_d  = ctime_q;
    if (bus.clear) begin
      buf_d   = 16'h0000;
      count_d = 3'd0;
    end else if (commit_go_s) begin
      commit_d = 1'b1;
      ctime_d  = commit_val_s;
      buf_d    = 16'h0000;
      count_d  = 3'd0;
      reject_d = press_done_s;
    end else if (press_done_s) begin
      if (bus.lock || (count_q == 3'd4)) begin
        reject_d = 1'b1;
      end else begin
        buf_d    = {buf_q[11:0], code_q};
        count_d  = count_q + 3'd1;
        strobe_d = 1'b1;
      end
    end else begin
      buf_d = buf_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= 4'd0;
      buf_q    <= 16'h0000;
      count_q  <= 3'd0;
      strobe_q <= 1'b0;
      reject_q <= 1'b0;
      commit_q <= 1'b0;
      ctime_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      reject_q <= reject_d;
      commit_q <= commit_d;
      ctime_q  <= ctime_d;
    end
  end

  assign bus.bcd_time    = buf_q;
  assign bus.digit_count = count_q;
  assign bus.key_strobe  = strobe_q;
  assign bus.key_reject  = reject_q;
  assign bus.commit      = commit_q;
  assign bus.commit_time = ctime_q;

endmodule

// File: tb/tb_keypad_time_entry_ctrl.sv
// Directed bench for keypad_time_entry_ctrl with a sample-stream reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_keypad_time_entry_ctrl;

  localparam int STABLE  = 4;
  localparam int RELEASE = 4;

  logic clk;
  logic reset;

  keypad_time_entry_if bus_if();

  keypad_time_entry_ctrl #(.STABLE_CYCLES(STABLE), .RELEASE_CYCLES(RELEASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  bit          m_armed = 1'b1;
  int          m_run   = 0;
  int          m_off   = 0;
  logic [3:0]  m_code  = 4'd0;
  int          m_q[$];
  logic [15:0] e_bcd    = 16'h0000;
  logic [15:0] e_ctime  = 16'h0000;
  logic [2:0]  e_cnt    = 3'd0;
  logic        e_strobe = 1'b0;
  logic        e_reject = 1'b0;
  logic        e_commit = 1'b0;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] buf_value();
    logic [15:0] v;
    v = 16'h0000;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  function automatic logic [15:0] norm_time(input logic [15:0] b);
    int mins;
    int secs;
    mins = int'(b[15:12]) * 10 + int'(b[11:8]);
    secs = int'(b[7:4]) * 10 + int'(b[3:0]);
`ifdef TIME_NORMALIZE_EN
    if (secs > 59) begin
      secs = secs - 60;
      mins = mins + 1;
      if (mins > 99) begin
        mins = 99;
        secs = 59;
      end
    end
`endif
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit press;
    bit valid;
    e_strobe = 1'b0;
    e_reject = 1'b0;
    e_commit = 1'b0;
    if (reset) begin
      m_armed = 1'b1; m_run = 0; m_off = 0;
      m_q.delete();
      e_ctime = 16'h0000;
      e_bcd   = 16'h0000;
      e_cnt   = 3'd0;
      return;
    end
    press = 1'b0;
    valid = (bus_if.digit <= 4'd9) && !bus_if.all_off;
    if (!bus_if.enable) begin
      m_armed = 1'b1; m_run = 0; m_off = 0;
    end else if (m_armed) begin
      if (!valid) m_run = 0;
      else if (m_run > 0 && bus_if.digit == m_code) m_run++;
      else begin
        m_code = bus_if.digit;
        m_run  = 1;
      end
      if (m_run == STABLE) begin
        press = 1'b1; m_armed = 1'b0; m_run = 0; m_off = 0;
      end
    end else begin
      if (bus_if.all_off) m_off++;
      else m_off = 0;
      if (m_off == RELEASE) begin
        m_armed = 1'b1; m_off = 0;
      end
    end
    if (bus_if.clear) begin
      m_q.delete();
    end else if (bus_if.start && !bus_if.lock && buf_value() != 16'h0000) begin
      e_commit = 1'b1;
      e_ctime  = norm_time(buf_value());
      m_q.delete();
      if (press) e_reject = 1'b1;
    end else if (press) begin
      if (bus_if.lock || m_q.size() == 4) e_reject = 1'b1;
      else begin
        m_q.push_back(int'(m_code));
        e_strobe = 1'b1;
      end
    end
    e_bcd = buf_value();
    e_cnt = 3'(m_q.size());
  endfunction

  // Compare every output against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    check("bcd_time",    bus_if.bcd_time,           e_bcd);
    check("digit_count", 16'(bus_if.digit_count),   16'(e_cnt));
    check("key_strobe",  16'(bus_if.key_strobe),    16'(e_strobe));
    check("key_reject",  16'(bus_if.key_reject),    16'(e_reject));
    check("commit",      16'(bus_if.commit),        16'(e_commit));
    check("commit_time", bus_if.commit_time,        e_ctime);
  end

  task automatic cyc(input logic [3:0] d, input logic off);
    bus_if.digit   = d;
    bus_if.all_off = off;
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0);
  endtask

  task automatic rel(input int n);
    for (int i = 0; i < n; i++) cyc(4'hF, 1'b1);
  endtask

  task automatic key(input logic [3:0] d);
    hold(d, STABLE);
    rel(RELEASE);
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    cyc(4'hF, 1'b1);
    bus_if.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_if.clear = 1'b1;
    cyc(4'hF, 1'b1);
    bus_if.clear = 1'b0;
  endtask

  logic [15:0] exp_9075;
  logic [15:0] exp_9975;

  initial begin
`ifdef TIME_NORMALIZE_EN
    exp_9075 = 16'h0130;
    exp_9975 = 16'h9959;
`else
    exp_9075 = 16'h0090;
    exp_9975 = 16'h9975;
`endif
    reset          = 1'b1;
    bus_if.enable  = 1'b1;
    bus_if.digit   = 4'hF;
    bus_if.all_off = 1'b1;
    bus_if.lock    = 1'b0;
    bus_if.clear   = 1'b0;
    bus_if.start   = 1'b0;
    cyc(4'hF, 1'b1);
    cyc(4'hF, 1'b1);
    reset = 1'b0;
    check("reset bcd", bus_if.bcd_time, 16'h0000);
    check("reset count", 16'(bus_if.digit_count), 16'd0);
    check("reset ctime", bus_if.commit_time, 16'h0000);

    // single clean press, held past acceptance
    hold(4'd5, 3);
    check("t1 early strobe", 16'(bus_if.key_strobe), 16'd0);
    hold(4'd5, 1);
    check("t1 strobe", 16'(bus_if.key_strobe), 16'd1);
    check("t1 bcd", bus_if.bcd_time, 16'h0005);
    check("t1 count", 16'(bus_if.digit_count), 16'd1);
    hold(4'd5, 8);
    check("t1 no retrigger", 16'(bus_if.digit_count), 16'd1);
    rel(6);

    // bouncy press restarts the debounce
    hold(4'd5, 1);
    hold(4'hF, 1);
    hold(4'd5, 3);
    check("t2 early strobe", 16'(bus_if.key_strobe), 16'd0);
    hold(4'd5, 1);
    check("t2 strobe", 16'(bus_if.key_strobe), 16'd1);
    check("t2 bcd", bus_if.bcd_time, 16'h0055);
    rel(4);

    // fill the buffer, fifth digit rejected
    pulse_clear();
    check("t3 cleared", bus_if.bcd_time, 16'h0000);
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    check("t3 bcd", bus_if.bcd_time, 16'h1230);
    hold(4'd7, 4);
    check("t3 reject", 16'(bus_if.key_reject), 16'd1);
    check("t3 count", 16'(bus_if.digit_count), 16'd4);
    rel(4);

    // commit 01:30
    pulse_clear();
    key(4'd1); key(4'd3); key(4'd0);
    check("t4 bcd", bus_if.bcd_time, 16'h0130);
    pulse_start();
    check("t4 commit", 16'(bus_if.commit), 16'd1);
    check("t4 ctime", bus_if.commit_time, 16'h0130);
    check("t4 bcd cleared", bus_if.bcd_time, 16'h0000);
    check("t4 count cleared", 16'(bus_if.digit_count), 16'd0);
    cyc(4'hF, 1'b1);
    check("t4 commit pulse", 16'(bus_if.commit), 16'd0);

    // 00:90 and 99:75 commits
    key(4'd9); key(4'd0);
    pulse_start();
    check("t5 ctime 0090", bus_if.commit_time, exp_9075);
    key(4'd9); key(4'd9); key(4'd7); key(4'd5);
    pulse_start();
    check("t6 ctime 9975", bus_if.commit_time, exp_9975);

    // clear + start together
    key(4'd4);
    bus_if.clear = 1'b1;
    bus_if.start = 1'b1;
    cyc(4'hF, 1'b1);
    bus_if.clear = 1'b0;
    bus_if.start = 1'b0;
    check("t7 no commit", 16'(bus_if.commit), 16'd0);
    check("t7 bcd", bus_if.bcd_time, 16'h0000);
    check("t7 ctime kept", bus_if.commit_time, exp_9975);

    // locked start and locked key
    key(4'd2);
    bus_if.lock = 1'b1;
    pulse_start();
    check("t8 no commit", 16'(bus_if.commit), 16'd0);
    check("t8 bcd", bus_if.bcd_time, 16'h0002);
    hold(4'd6, 4);
    check("t9 lock reject", 16'(bus_if.key_reject), 16'd1);
    check("t9 bcd", bus_if.bcd_time, 16'h0002);
    rel(4);
    bus_if.lock = 1'b0;

    // start coincides with an accepted digit
    hold(4'd8, 3);
    bus_if.start = 1'b1;
    hold(4'd8, 1);
    bus_if.start = 1'b0;
    check("t11 commit", 16'(bus_if.commit), 16'd1);
    check("t11 reject", 16'(bus_if.key_reject), 16'd1);
    check("t11 ctime", bus_if.commit_time, 16'h0002);
    check("t11 bcd", bus_if.bcd_time, 16'h0000);
    rel(4);

    // start on an empty buffer
    pulse_start();
    check("t10 no commit", 16'(bus_if.commit), 16'd0);
    check("t10 ctime", bus_if.commit_time, 16'h0002);

    // enable drop mid-debounce discards the press
    hold(4'd3, 2);
    bus_if.enable = 1'b0;
    hold(4'd3, 1);
    bus_if.enable = 1'b1;
    hold(4'd3, 3);
    check("t12 no strobe", 16'(bus_if.key_strobe), 16'd0);
    hold(4'd3, 1);
    check("t12 strobe", 16'(bus_if.key_strobe), 16'd1);
    check("t12 bcd", bus_if.bcd_time, 16'h0003);
    rel(4);

    // reset during debounce
    hold(4'd4, 2);
    reset = 1'b1;
    hold(4'd4, 1);
    reset = 1'b0;
    check("t13 bcd", bus_if.bcd_time, 16'h0000);
    check("t13 count", 16'(bus_if.digit_count), 16'd0);
    check("t13 ctime", bus_if.commit_time, 16'h0000);
    check("t13 strobe", 16'(bus_if.key_strobe), 16'd0);
    rel(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
